// File: rtl/lag_meter.sv
// lag_meter: measures display input lag in microseconds from frame_start to debounced photodiode light.
module lag_meter #(
  parameter int US_DIV          = 74,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_US      = 250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        sensor,
  output logic [17:0] lag_us,
  output logic        lag_valid,
  output logic [17:0] lag_avg_us,
  output logic        avg_valid,
  output logic        timeout,
  output logic        busy
);
  localparam int PW = $clog2(US_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, MEASURE, HOLDOFF} state_t;
  state_t state;
  logic [1:0] sync;
  logic deb;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pre;
  logic [17:0] us;
  logic [21:0] acc;
  logic [3:0] cnt;
  logic pre_wrap;
  logic [17:0] us_nx;
  logic [21:0] acc_nx;
  logic deb_hit;
  assign pre_wrap = pre == PW'(US_DIV - 1);
  // us_nx counts the current cycle too, so the latched lag is floor((N+D)/US_DIV)
  assign us_nx    = us + 18'(pre_wrap);
  assign acc_nx   = acc + 22'(us_nx);
  assign deb_hit  = deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync    <= '0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync    <= {sync[0], sensor};
      deb     <= (sync[1] != deb && deb_hit) ? sync[1] : deb;
      deb_cnt <= (sync[1] != deb && !deb_hit) ? deb_cnt + DW'(1) : '0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pre        <= '0;
      us         <= '0;
      acc        <= '0;
      cnt        <= '0;
      lag_us     <= '0;
      lag_valid  <= 1'b0;
      lag_avg_us <= '0;
      avg_valid  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lag_valid <= 1'b0;
      avg_valid <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          // a frame_start while the screen already reads light is not a valid start
          if (frame_start && !deb) begin
            pre   <= '0;
            us    <= '0;
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          pre <= pre_wrap ? '0 : pre + PW'(1);
          us  <= us_nx;
          if (deb) begin
            lag_us    <= us_nx;
            lag_valid <= 1'b1;
            state     <= HOLDOFF;
            cnt       <= cnt + 4'd1;
            acc       <= (cnt == 4'd15) ? '0 : acc_nx;
            if (cnt == 4'd15) begin
              lag_avg_us <= 18'(acc_nx >> 4);
              avg_valid  <= 1'b1;
            end
          end else if (us_nx == 18'(TIMEOUT_US)) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (!deb) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lag_meter.sv
// tb_lag_meter: randomized self-checking bench for lag_meter against a formula-level lag/average model.
module tb_lag_meter;
  localparam int DIV = 4;
  localparam int DB  = 2;
  localparam int TO  = 1000;
  localparam int D   = 2 + DB;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic frame_start = 1'b0;
  logic sensor = 1'b0;
  logic [17:0] lag_us, lag_avg_us;
  logic lag_valid, avg_valid, timeout, busy;
  int n_cmp = 0;
  int n_bad = 0;
  int last_lag = 0;
  int exp_avg = 0;
  int samples[$];
  lag_meter #(.US_DIV(DIV), .DEBOUNCE_CYCLES(DB), .TIMEOUT_US(TO)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .sensor(sensor),
    .lag_us(lag_us), .lag_valid(lag_valid), .lag_avg_us(lag_avg_us),
    .avg_valid(avg_valid), .timeout(timeout), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic model_reset;
    last_lag = 0;
    exp_avg = 0;
    samples.delete();
  endtask
  // One frame: n = first cycle (after the frame_start edge) the sensor is sampled high, -1 = never.
  task automatic measure(input int n, input int glitch, input int fs_extra, input string name);
    bit ev, ea;
    int ek, dk, fk, el, nv, nt, na, kv, kt, ka, bb, sum;
    logic [17:0] lv;
    ev = n >= 0 && n + D <= TO * DIV;
    ek = ev ? n + D : TO * DIV;
    dk = ek + 3;
    fk = ev ? dk + D : ek + 1;
    el = ev ? ek / DIV : last_lag;
    ea = 0; nv = 0; nt = 0; na = 0; kv = -1; kt = -1; ka = -1; lv = '0;
    sensor = (n == 0) || (glitch == 0);
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    bb = int'(busy !== 1'b1);
    for (int k = 1; k <= fk + 3; k++) begin
      sensor = (k == glitch) || (ev && k >= n && k < dk);
      frame_start = (k == fs_extra);
      step;
      if (lag_valid === 1'b1) begin nv++; kv = k; lv = lag_us; end
      if (timeout === 1'b1) begin nt++; kt = k; end
      if (avg_valid === 1'b1) begin na++; ka = k; end
      bb += int'(busy !== (k < fk));
    end
    sensor = 1'b0;
    frame_start = 1'b0;
    if (ev) begin
      last_lag = el;
      samples.push_back(el);
      if (samples.size() == 16) begin
        sum = 0;
        foreach (samples[i]) sum += samples[i];
        exp_avg = sum / 16;
        ea = 1;
        samples.delete();
      end
    end
    n_cmp++;
    if (ev ? (nv !== 1 || kv !== ek) : (nv !== 0)) begin
      n_bad++;
      $display("FAIL %s lag_valid: got %0d pulses last at k=%0d, want %0d at k=%0d", name, nv, kv, ev ? 1 : 0, ek);
    end
    n_cmp++;
    if (ev ? (nt !== 0) : (nt !== 1 || kt !== ek)) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d pulses last at k=%0d, want %0d at k=%0d", name, nt, kt, ev ? 0 : 1, ek);
    end
    if (ev) begin
      n_cmp++;
      if (lv !== 18'(el)) begin
        n_bad++;
        $display("FAIL %s lag_at_pulse: got %0d want %0d", name, lv, el);
      end
    end
    n_cmp++;
    if (lag_us !== 18'(last_lag)) begin
      n_bad++;
      $display("FAIL %s lag_us_held: got %0d want %0d", name, lag_us, last_lag);
    end
    n_cmp++;
    if (ea ? (na !== 1 || ka !== ek) : (na !== 0)) begin
      n_bad++;
      $display("FAIL %s avg_valid: got %0d pulses last at k=%0d, want %0d at k=%0d", name, na, ka, ea ? 1 : 0, ek);
    end
    n_cmp++;
    if (lag_avg_us !== 18'(exp_avg)) begin
      n_bad++;
      $display("FAIL %s lag_avg_us: got %0d want %0d", name, lag_avg_us, exp_avg);
    end
    n_cmp++;
    if (bb !== 0) begin
      n_bad++;
      $display("FAIL %s busy_profile: got %0d wrong cycles want 0 (busy expected until k=%0d)", name, bb, fk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) step;
    n_cmp++;
    if ({lag_us, lag_valid, lag_avg_us, avg_valid, timeout, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got lag=%0d lv=%b avg=%0d av=%b to=%b busy=%b want all 0",
               lag_us, lag_valid, lag_avg_us, avg_valid, timeout, busy);
    end
    reset = 1'b1;
    step;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
    model_reset();
  endtask
  task automatic test_basic;
    measure(400, -1, -1, "basic");
  endtask
  task automatic test_dark_screen;
    int bad;
    sensor = 1'b1;
    repeat (8) step;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    bad = 0;
    repeat (12) begin
      bad += int'(busy !== 1'b0) + int'(lag_valid !== 1'b0) + int'(timeout !== 1'b0);
      step;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL dark_ignore: got %0d active output samples want 0", bad);
    end
    sensor = 1'b0;
    repeat (8) step;
    measure($urandom_range(100, 300), -1, -1, "dark_rearm");
  endtask
  task automatic test_timeout;
    measure(-1, -1, -1, "timeout");
  endtask
  task automatic test_debounce;
    measure(800, $urandom_range(100, 300), $urandom_range(20, 60), "debounce");
  endtask
  task automatic test_boundary;
    measure(0, -1, -1, "immediate_light");
    measure(TO * DIV - D, -1, -1, "tie_valid_wins");
  endtask
  task automatic test_averaging;
    reset = 1'b0;
    step;
    reset = 1'b1;
    step;
    model_reset();
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) measure(-1, -1, -1, "avg_timeout");
      measure(4 * 10 * i - 4 + $urandom_range(0, 3), -1, -1, $sformatf("avg_%0d", i));
    end
    n_cmp++;
    if (lag_avg_us !== 18'd85) begin
      n_bad++;
      $display("FAIL avg_block: got %0d want 85", lag_avg_us);
    end
  endtask
  task automatic test_reset_mid;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    repeat (200) step;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({lag_us, lag_valid, lag_avg_us, avg_valid, timeout, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got lag=%0d lv=%b avg=%0d av=%b to=%b busy=%b want all 0",
               lag_us, lag_valid, lag_avg_us, avg_valid, timeout, busy);
    end
    repeat (3) step;
    reset = 1'b1;
    step;
    model_reset();
    measure(400, -1, -1, "post_reset");
  endtask
  task automatic test_random;
    int n, g;
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 1500);
      g = (n > 20) ? $urandom_range(1, n - 3) : -1;
      measure(n, g, -1, $sformatf("random_%0d", i));
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_dark_screen();
    test_timeout();
    test_debounce();
    test_boundary();
    test_random();
    test_averaging();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
